// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared configuration for the weight-stationary systolic tile sequencer:
// array geometry, vector-count width and the controller state encoding.
package systolic_seq_ctrl_pkg;

    localparam int SMALL_SYS_ROWS = 4;
    localparam int SMALL_SYS_COLS = 4;
    localparam int SYS_CTRL_M_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        GAP,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_e;

    // Cycles spent in DRAIN. The last base strobe appears the cycle after
    // STREAM ends, then needs ROWS+COLS-1 more cycles to reach the last
    // column, plus one cycle for that column's valid to fall.
    function automatic int drain_cycles(input int rows, input int cols);
        return rows + cols + 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew.sv
// Single-bit delay line with every tap exposed: taps[i] is din delayed
// i+1 cycles. Used to build the row skew on if_en and the column skew
// on of_valid. Asynchronous active-low reset clears all taps.
module skew_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    logic [DEPTH-1:0] taps_reg;

    // Shift din through the chain, one stage per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps_reg <= '0;
        end else begin
            taps_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_reg[i] <= taps_reg[i-1];
            end
        end
    end

    assign taps = taps_reg;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Control/address sequencer for a ROWS x COLS weight-stationary systolic
// tile: loads weights bottom row first, streams m_len activation vectors,
// generates the row skew on if_en and the per-column of_valid skew.
// Optional macro SYS_CTRL_PERF_EN adds cyc_cnt/tile_cnt performance
// counters. ROWS must be at least 2 so the weight row address has a width.
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int ROWS   = SMALL_SYS_ROWS,
    parameter int COLS   = SMALL_SYS_COLS,
    parameter int M_W    = SYS_CTRL_M_W,
    parameter int ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [M_W-1:0]          m_len,
    output logic                    busy,
    output logic                    done,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_rd_addr,
    output logic [COLS-1:0]         wfetch,
    output logic                    if_rd_en,
    output logic [ADDR_W-1:0]       if_rd_addr,
    output logic [ROWS-1:0]         if_en,
    output logic [COLS-1:0]         of_valid
`ifdef SYS_CTRL_PERF_EN
    ,
    output logic [31:0]             cyc_cnt,
    output logic [15:0]             tile_cnt
`endif
);

    localparam int RA_W      = $clog2(ROWS);
    localparam int DRAIN_CYC = drain_cycles(ROWS, COLS);
    localparam int DC_W      = $clog2(DRAIN_CYC);

    localparam logic [RA_W-1:0] LAST_ROW  = RA_W'(ROWS - 1);
    localparam logic [DC_W-1:0] DRAIN_END = DC_W'(DRAIN_CYC - 1);

    ctrl_state_e       state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              w_rd_en_reg;
    logic [RA_W-1:0]   w_rd_addr_reg;
    logic              wfetch_reg;
    logic              if_rd_en_reg;
    logic [ADDR_W-1:0] if_rd_addr_reg;
    logic [M_W-1:0]    m_len_reg;
    logic [M_W-1:0]    v_reg;
    logic [DC_W-1:0]   drain_reg;

    // Tile FSM with registered strobes and addresses. The weight address
    // counts down from the bottom row, so it doubles as the load counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            w_rd_en_reg    <= 1'b0;
            w_rd_addr_reg  <= '0;
            if_rd_en_reg   <= 1'b0;
            if_rd_addr_reg <= '0;
            m_len_reg      <= '0;
            v_reg          <= '0;
            drain_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_len_reg     <= m_len;
                        busy_reg      <= 1'b1;
                        w_rd_en_reg   <= 1'b1;
                        w_rd_addr_reg <= LAST_ROW;
                        state_reg     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_rd_addr_reg == '0) begin
                        w_rd_en_reg <= 1'b0;
                        state_reg   <= GAP;
                    end else begin
                        w_rd_addr_reg <= w_rd_addr_reg - RA_W'(1);
                    end
                end
                GAP: begin
                    // Last wfetch happens here, so weights settle before
                    // the first activation enable.
                    if (m_len_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        if_rd_en_reg   <= 1'b1;
                        if_rd_addr_reg <= '0;
                        v_reg          <= '0;
                        state_reg      <= STREAM;
                    end
                end
                STREAM: begin
                    if (v_reg == m_len_reg - M_W'(1)) begin
                        if_rd_en_reg <= 1'b0;
                        drain_reg    <= '0;
                        state_reg    <= DRAIN;
                    end else begin
                        v_reg          <= v_reg + M_W'(1);
                        if_rd_addr_reg <= if_rd_addr_reg + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Fixed wait equal to the time for the skew chains to
                    // empty behind the last vector.
                    if (drain_reg == DRAIN_END) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        drain_reg <= drain_reg + DC_W'(1);
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Weight shift enable follows the weight read strobe by the buffer's
    // one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wfetch_reg <= 1'b0;
        end else begin
            wfetch_reg <= w_rd_en_reg;
        end
    end

    // Row skew: if_en[r] is the read strobe delayed 1+r cycles, i.e. the
    // base strobe s (tap 0) delayed r more.
    skew_delay_line #(
        .DEPTH(ROWS)
    ) u_if_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (if_rd_en_reg),
        .taps (if_en)
    );

    // Column skew: of_valid[c] is s delayed ROWS+c cycles, fed from the
    // bottom row enable.
    skew_delay_line #(
        .DEPTH(COLS)
    ) u_of_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (if_en[ROWS-1]),
        .taps (of_valid)
    );

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign w_rd_en    = w_rd_en_reg;
    assign w_rd_addr  = w_rd_addr_reg;
    assign wfetch     = {COLS{wfetch_reg}};
    assign if_rd_en   = if_rd_en_reg;
    assign if_rd_addr = if_rd_addr_reg;

`ifdef SYS_CTRL_PERF_EN
    logic [31:0] cyc_cnt_reg;
    logic [15:0] tile_cnt_reg;

    // Busy-cycle count of the most recent tile, plus a wrapping tile count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_reg  <= '0;
            tile_cnt_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                cyc_cnt_reg <= '0;
            end else if (busy_reg) begin
                cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
            end
            if (done_reg) begin
                tile_cnt_reg <= tile_cnt_reg + 16'd1;
            end
        end
    end

    assign cyc_cnt  = cyc_cnt_reg;
    assign tile_cnt = tile_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (ROWS=COLS=4, M_W=ADDR_W=9).
// Cycle 0 is the cycle in which start is high; outputs are sampled on the
// falling edge. Each tile record holds hand-computed event cycles.
module tb_systolic_seq_ctrl;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int M_W    = 9;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [M_W-1:0]    m_len = '0;
    logic              busy;
    logic              done;
    logic              w_rd_en;
    logic [1:0]        w_rd_addr;
    logic [COLS-1:0]   wfetch;
    logic              if_rd_en;
    logic [ADDR_W-1:0] if_rd_addr;
    logic [ROWS-1:0]   if_en;
    logic [COLS-1:0]   of_valid;
`ifdef SYS_CTRL_PERF_EN
    logic [31:0]       cyc_cnt;
    logic [15:0]       tile_cnt;
`endif

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .M_W    (M_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m_len      (m_len),
        .busy       (busy),
        .done       (done),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .wfetch     (wfetch),
        .if_rd_en   (if_rd_en),
        .if_rd_addr (if_rd_addr),
        .if_en      (if_en),
        .of_valid   (of_valid)
`ifdef SYS_CTRL_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .tile_cnt   (tile_cnt)
`endif
    );

    typedef struct {
        int m_len;
        int pulse;    // 1: toggle start during STREAM and in the DONE cycle
        int done_c;
        int busy_n;
        int ie0_f, ie0_l;
        int ie3_f, ie3_l;
        int ov0_f, ov0_l;
        int ov3_f, ov3_l;
    } vec_t;

    vec_t vecs[5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void upd(input logic b, input int cyc,
                                inout int f, inout int l, inout int n);
        if (b) begin
            if (f < 0) f = cyc;
            l = cyc;
            n++;
        end
    endfunction

    function automatic int out_bits();
        return int'({busy, done, w_rd_en, if_rd_en, wfetch, if_en, of_valid});
    endfunction

    task automatic run_tile(input vec_t v);
        int wr_f = -1, wr_l = -1, wr_n = 0;
        int wf_f = -1, wf_l = -1, wf_n = 0;
        int ie0_f = -1, ie0_l = -1, ie0_n = 0;
        int ie3_f = -1, ie3_l = -1, ie3_n = 0;
        int ov0_f = -1, ov0_l = -1, ov0_n = 0;
        int ov3_f = -1, ov3_l = -1, ov3_n = 0;
        int ir_n = 0, done_n = 0, done_c = -1, busy_n = 0;
        int addr_err = 0, iaddr_err = 0, wf_err = 0;
        int post_busy = -1, post_act = -1;
        int finished = 0;
        m_len = M_W'(v.m_len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 1000 && finished == 0; cyc++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = cyc;
            end
            if (w_rd_en && int'(w_rd_addr) != ROWS - 1 - wr_n) addr_err++;
            upd(w_rd_en, cyc, wr_f, wr_l, wr_n);
            if (wfetch != '0 && wfetch != '1) wf_err++;
            upd(wfetch[0], cyc, wf_f, wf_l, wf_n);
            if (if_rd_en) begin
                if (int'(if_rd_addr) != ir_n) iaddr_err++;
                ir_n++;
            end
            upd(if_en[0], cyc, ie0_f, ie0_l, ie0_n);
            upd(if_en[3], cyc, ie3_f, ie3_l, ie3_n);
            upd(of_valid[0], cyc, ov0_f, ov0_l, ov0_n);
            upd(of_valid[3], cyc, ov3_f, ov3_l, ov3_n);
            if (done_c > 0 && cyc == done_c + 1) begin
                post_busy = int'(busy);
                post_act  = out_bits();
                finished  = 1;
            end
            if (v.pulse != 0 && ((cyc >= 6 && cyc <= 8) || done)) start = 1'b1;
            else start = 1'b0;
            if (finished == 0) @(negedge clk);
        end
        start = 1'b0;
        $display("tile m_len=%0d pulse=%0d done_cyc=%0d busy_cycles=%0d",
                 v.m_len, v.pulse, done_c, busy_n);
        chk("tile_finished", finished, 1);
        chk("done_count", done_n, 1);
        chk("done_cycle", done_c, v.done_c);
        chk("busy_cycles", busy_n, v.busy_n);
        chk("post_busy", post_busy, 0);
        chk("post_outputs", post_act, 0);
        chk("w_rd_en_first", wr_f, 1);
        chk("w_rd_en_last", wr_l, 4);
        chk("w_rd_addr_order_errors", addr_err, 0);
        chk("wfetch_first", wf_f, 2);
        chk("wfetch_last", wf_l, 5);
        chk("wfetch_count", wf_n, ROWS);
        chk("wfetch_bits_unequal", wf_err, 0);
        chk("if_rd_en_count", ir_n, v.m_len);
        chk("if_rd_addr_errors", iaddr_err, 0);
        chk("if_en0_first", ie0_f, v.ie0_f);
        chk("if_en0_last", ie0_l, v.ie0_l);
        chk("if_en0_count", ie0_n, v.m_len);
        chk("if_en3_first", ie3_f, v.ie3_f);
        chk("if_en3_last", ie3_l, v.ie3_l);
        chk("of_valid0_first", ov0_f, v.ov0_f);
        chk("of_valid0_last", ov0_l, v.ov0_l);
        chk("of_valid3_first", ov3_f, v.ov3_f);
        chk("of_valid3_last", ov3_l, v.ov3_l);
        chk("of_valid3_count", ov3_n, v.m_len);
    endtask

    initial begin
        int dn;
        vecs[0] = '{3,   0, 18,  18,  7, 9,   10, 12,  11, 13,  14, 16};
        vecs[1] = '{0,   0, 6,   6,   -1, -1, -1, -1,  -1, -1,  -1, -1};
        vecs[2] = '{1,   0, 16,  16,  7, 7,   10, 10,  11, 11,  14, 14};
        vecs[3] = '{3,   1, 18,  18,  7, 9,   10, 12,  11, 13,  14, 16};
        vecs[4] = '{511, 0, 526, 526, 7, 517, 10, 520, 11, 521, 14, 524};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_bits(), 0);
        chk("reset_w_rd_addr", int'(w_rd_addr), 0);
        chk("reset_if_rd_addr", int'(if_rd_addr), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_tile(vecs[i]);
        end

        // Reset in mid-STREAM aborts the tile immediately
        m_len = M_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_if_en0", int'(if_en[0]), 1);
        chk("pre_reset_busy", int'(busy), 1);
        #1 rst = 1'b0;
        #1;
        chk("abort_outputs", out_bits(), 0);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_idle_busy", int'(busy), 0);

        // A fresh start after the abort behaves like the first tile
        run_tile(vecs[0]);

`ifdef SYS_CTRL_PERF_EN
        // Second tile back to back with the one above
        run_tile(vecs[0]);
        chk("perf_cyc_cnt", int'(cyc_cnt), 18);
        chk("perf_tile_cnt", int'(tile_cnt), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
